// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the ALU operand stage and the multiply/divide unit.
// No latency of its own; wires only.
// Backpressure: the core holds off new requests while busy is high.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a_alu;
    logic [XLEN-1:0] b_alu;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Core side: issues operations, observes completion
    modport master (
        output start, kill, funct3, a_alu, b_alu,
        input  busy, done, result
    );

    // Unit side
    modport slave (
        input  start, kill, funct3, a_alu, b_alu,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: accepting edge to result edge is XLEN+1 edges for every op, including special cases.
// Backpressure: start is only looked at in IDLE; requests while busy are dropped, kill aborts.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   a_q;        // original operands, kept for the special-case overrides
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   mag_b_q;    // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [CW-1:0]     cnt_q;
    logic              neg_q;      // sign of product / quotient
    logic              rneg_q;     // sign of remainder
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] acc_d;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, quo_s, rem_s;
    logic              div0, ovf;
    logic [XLEN-1:0]   result_d;

    // Decode signedness of the incoming request and take operand magnitudes
    always_comb begin
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        a_neg    = a_signed & bus.a_alu[XLEN-1];
        b_neg    = b_signed & bus.b_alu[XLEN-1];
        mag_a    = a_neg ? -bus.a_alu : bus.a_alu;
        mag_b    = b_neg ? -bus.b_alu : bus.b_alu;
    end

    // One iteration of either shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mag_b_q};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        acc_d     = acc_q;
        if (funct3_q[2]) begin
            // Negative trial difference means the divisor did not fit: restore
            if (div_diff[XLEN])
                acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            else
                acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            if (acc_q[0])
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            else
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    // Sign fix-up and special-case overrides applied when entering DONE
    always_comb begin
        prod  = neg_q ? -acc_q : acc_q;
        quo   = acc_q[XLEN-1:0];
        rem   = acc_q[2*XLEN-1:XLEN];
        quo_s = neg_q ? -quo : quo;
        rem_s = rneg_q ? -rem : rem;
        div0  = (b_q == '0);
        ovf   = !funct3_q[0] && (a_q == MOST_NEG) && (b_q == '1);
        result_d = '0;
        case (funct3_q)
            3'b000:  result_d = prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  result_d = prod[2*XLEN-1:XLEN];
            3'b100:  result_d = div0 ? '1 : (ovf ? MOST_NEG : quo_s);
            3'b101:  result_d = div0 ? '1 : quo;
            3'b110:  result_d = div0 ? a_q : (ovf ? '0 : rem_s);
            default: result_d = div0 ? a_q : rem;
        endcase
    end

    // Control FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.kill) begin
                        funct3_q <= bus.funct3;
                        a_q      <= bus.a_alu;
                        b_q      <= bus.b_alu;
                        mag_b_q  <= mag_b;
                        acc_q    <= {{XLEN{1'b0}}, mag_a};
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (bus.kill) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == CW'(XLEN)) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
